// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
//   SEG_OFF  : active-low segment pattern with every segment dark
//   PHASES   : PWM phases per digit slot
//   HEX_SEG  : active-low hex font, bit 6 = g .. bit 0 = a
//   slot_t   : per-slot snapshot of the inputs for the digit being shown
package sseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam int         PHASES  = 16;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] digit;
    logic       dp;
    logic       en;
    logic       lz;
    logic [3:0] bright;
  } slot_t;

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex to active-low seven-segment decoder.
//   hex : 4-bit value 0..F
//   seg : active-low segments, seg[6]=g .. seg[0]=a
module hex7seg_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/sseg_mux_driver_n.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
// with per-digit decimal point and enable, leading-zero blanking, 4-bit PWM
// brightness and a dark phase 0 in every slot for anti-ghosting.
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low
//   digits     : packed hex values, digit i = digits[4*i+3:4*i], digit 0 rightmost
//   dp_in      : decimal point request per digit, 1 = lit
//   en         : digit enable, 0 = digit dark for its slot
//   blank_lz   : 1 = suppress leading zeros
//   brightness : PWM level 0..15
//   sseg       : active-low segments (registered)
//   dp         : active-low decimal point (registered)
//   AN         : active-low anodes, at most one low (registered)
//   frame_tick : one-cycle pulse at the start of each full scan (registered)
module sseg_mux_driver_n
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int PHASE_CYCLES = 6250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [3:0]       PHASE_LAST = 4'(PHASES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      phase_cnt_q, phase_cnt_d;
  logic [3:0]            phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  started_q, started_d;
  slot_t                 slot_q, slot_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            sseg_q, sseg_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  cnt_last;
  logic                  boundary;
  logic [IDX_W-1:0]      idx_next;
  logic [IDX_W-1:0]      sel;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            dig_arr [NUM_DIGITS];
  logic [6:0]            seg_dec;
  logic                  phase_lit;

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_arr[i] = digits[4*i +: 4];
    end
  end

  // Walk from the most significant digit down, tracking whether every digit
  // at or above the current position is zero.
  always_comb begin
    logic        zero_above;
    int unsigned pos;
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      pos          = NUM_DIGITS - 1 - j;
      zero_above   = zero_above && (digits[4*pos +: 4] == 4'h0);
      lz_mask[pos] = blank_lz && (pos != 0) && zero_above;
    end
  end

  always_comb begin
    cnt_last    = (phase_cnt_q == CNT_LAST);
    boundary    = cnt_last && (phase_q == PHASE_LAST);
    idx_next    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    phase_cnt_d = cnt_last ? '0 : phase_cnt_q + 1'b1;
    phase_d     = cnt_last ? phase_q + 4'd1 : phase_q;
    idx_d       = boundary ? idx_next : idx_q;
    started_d   = started_q || boundary;
  end

  // Slot registers also load while reset is held, capturing digit 0 so the
  // first slot after release already has valid data without a boundary.
  always_comb begin
    sel    = reset ? idx_next : '0;
    slot_d = slot_q;
    if (boundary || !reset) begin
      slot_d.digit  = dig_arr[sel];
      slot_d.dp     = dp_in[sel];
      slot_d.en     = en[sel];
      slot_d.lz     = lz_mask[sel];
      slot_d.bright = brightness;
    end
  end

  hex7seg_decoder u_dec (
    .hex (slot_q.digit),
    .seg (seg_dec)
  );

  // Outputs are computed from the current counter state and slot registers,
  // so they trail the counters by exactly one cycle.
  always_comb begin
    phase_lit    = (phase_q != 4'd0) && (phase_q <= slot_q.bright);
    an_d         = '1;
    if (phase_lit && slot_q.en && (!slot_q.lz || slot_q.dp)) begin
      an_d[idx_q] = 1'b0;
    end
    sseg_d       = (slot_q.lz || !slot_q.en) ? SEG_OFF : seg_dec;
    dp_d         = !(slot_q.dp && slot_q.en);
    frame_tick_d = started_q && (phase_cnt_q == '0) && (phase_q == 4'd0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_cnt_q  <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      started_q    <= 1'b0;
      an_q         <= '1;
      sseg_q       <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      phase_cnt_q  <= phase_cnt_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      started_q    <= started_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  assign sseg       = sseg_q;
  assign dp         = dp_q;
  assign AN         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/sseg_mux_driver_n.md
Name: sseg_mux_driver_n

Overview:
Parametrised time-multiplexed seven-segment display driver for NUM_DIGITS common-anode digits (Basys3: 4, Nexys A7: 8). It is the generalised successor to the team's 4-digit sseg_driver and adds:
- per-digit decimal points and per-digit enables
- optional leading-zero blanking
- 4-bit PWM brightness
- a fixed anti-ghosting dead phase
It sits between the counter/datapath logic and the board pins; all outputs are registered.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16).
PHASE_CYCLES, 6250, clk cycles per PWM phase. One digit slot = 16*PHASE_CYCLES cycles (1 ms at 100 MHz). Must be >= 1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
digits  input  4*NUM_DIGITS  packed hex values; digit i = digits[4*i+3:4*i], digit 0 is rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
en  input  NUM_DIGITS  digit enable, 0 = digit dark for its slot
blank_lz  input  1  1 = suppress leading zeros
brightness  input  4  PWM level 0..15
sseg  output  7  active-low segments, sseg[6]=g .. sseg[0]=a
dp  output  1  active-low decimal point
AN  output  NUM_DIGITS  active-low anodes, at most one low at any time
frame_tick  output  1  one-cycle pulse at the start of each full scan

Behaviour:
- Reset (reset==0 at a rising edge):
  - phase_cnt, phase, idx = 0
  - AN = all 1s, sseg = 7'h7F, dp = 1, frame_tick = 0
  - Reset asserted mid-scan aborts immediately; the scan restarts at digit 0 one cycle after release.
- Timing chain:
  - phase_cnt counts 0..PHASE_CYCLES-1.
  - At its terminal count, the 4-bit phase increments (mod 16).
  - When phase wraps 15->0, idx increments mod NUM_DIGITS. idx width = max(1, clog2(NUM_DIGITS)).
- Slot boundary (cycle where phase_cnt and phase are both terminal):
  - Snapshot digit[idx_next], dp_in, en, the LZ mask and brightness into slot registers.
  - Inputs changing mid-slot have no effect until the next slot.
- Leading-zero mask:
  - Digit i is LZ-blanked iff blank_lz=1, i != 0, and digits i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked (value 0 shows "0").
- Segment output:
  - Registered; valid from the first cycle of phase 0 of the slot.
  - Hex 0-F decoded active-low: 0=7'h40, 1=7'h79, 8=7'h00, A=7'h08, F=7'h0E.
  - LZ-blanked or en=0: sseg = 7'h7F.
- dp output: 0 iff slot dp_in=1 and en=1, including on an LZ-blanked digit.
- Anode output:
  - AN[idx] = 0 iff all hold: 1 <= phase <= slot brightness; en=1; the digit is not LZ-blanked OR its dp_in=1.
  - All other AN bits = 1.
  - Phase 0 is always dark (dead time for segment changes).
  - brightness 0: fully dark. brightness 15: on 15/16 of the slot.
- frame_tick: 1 for exactly the one cycle in which phase 0 of digit 0 starts (registered, aligned with AN/sseg update). Not asserted for the first scan after reset.
- NUM_DIGITS=1: idx is stuck at 0; frame_tick pulses every slot after the first.

Decomposition:
- Shared package sseg_pkg:
  - SEG_OFF = 7'h7F
  - the 16-entry active-low hex segment table
  - PHASES = 16
- Sub-module hex7seg_decoder: combinational 4-bit to 7-bit active-low decoder using the package table; instantiated once on the snapshotted digit.
- Everything else (counters, mask, PWM compare, output registers) lives in sseg_mux_driver_n.

Test Plan:
All scenarios use NUM_DIGITS=4 and PHASE_CYCLES=2 (slot = 32 cycles, frame = 128 cycles).

1. Reset held 5 cycles -> AN=4'hF, sseg=7'h7F, dp=1, frame_tick=0. Release -> AN[0] first goes low on cycle 3 (phase 1) with brightness=15.
2. digits=16'h3210, en=4'hF, brightness=15, blank_lz=0 -> AN scans 1110,1101,1011,0111 with sseg 40,79,24,30. Each anode is low 30 of 32 cycles and never overlaps another. frame_tick period = 128 cycles.
3. digits=16'h0070, blank_lz=1, dp_in=4'b0100 -> digit3: AN stays high. Digit2: AN low, sseg=7F, dp=0. Digit1 shows 7'h78. Digit0 shows 7'h40.
4. brightness=4 -> per slot, AN low exactly 8 cycles (phases 1..4). brightness=0 -> AN=4'hF throughout.
5. Change digits from 16'h1111 to 16'h2222 in the middle of digit-1's slot -> digit 1 still shows 7'h79 until its next slot. Digit 2 shows 7'h24.
6. Assert reset during digit-2 slot -> outputs return to reset values on the next edge. The scan restarts at digit 0 after release.
